ps2_kbd_cmd_sequencer: RTL and testbench
========================================

# ps2_kbd_cmd_sequencer

- Host-side command sequencer for the PS/2 keyboard port.
- After reset it runs the keyboard initialisation handshake: 0xFF reset, ACK, then BAT result. It then services LED-update requests with the 0xED + argument exchange, including resend handling, timeouts and bounded retries.
- It sits between the PS/2 byte transmitter/receiver and downstream scancode consumers. In normal operation it forwards keyboard bytes; it intercepts protocol responses while a command is in flight.

## Interface

Parameters:
- TIMEOUT_CYCLES, 2_000_000, clk cycles to wait for any keyboard response after a byte is sent (also used for BAT wait)
- MAX_RETRY, 3, resends allowed per byte before entering ERROR

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- reinit  input  1  one-cycle pulse; restarts the init sequence from any state
- led_update  input  1  one-cycle pulse; request to send led_state to the keyboard
- led_state  input  3  {caps, num, scroll}; sampled when led_update=1
- tx_data  output  8  byte to transmit; stable from tx_start until tx_busy falls
- tx_start  output  1  one-cycle pulse launching a transmission
- tx_busy  input  1  transmitter busy
- rx_data  input  8  received byte
- rx_valid  input  1  one-cycle pulse; rx_data valid
- scan_data  output  8  forwarded keyboard byte
- scan_valid  output  1  one-cycle pulse; scan_data valid
- kb_ready  output  1  init completed OK; no error
- kb_busy  output  1  command sequence in progress
- kb_error  output  1  init failed or retries exhausted

## Operation

- All outputs are registered.
- Reset values: tx_data=0x00, tx_start=0, scan_data=0x00, scan_valid=0, kb_ready=0, kb_busy=1, kb_error=0.
- FSM states:
  - RST_SEND: wait tx_busy=0, pulse tx_start with tx_data=0xFF -> RST_ACK.
  - RST_ACK:
    - 0xFA -> BAT_WAIT
    - 0xFE or timeout -> resend 0xFF
    - other bytes discarded
  - BAT_WAIT:
    - 0xAA -> IDLE
    - 0xFC/0xFD or timeout -> ERROR
    - other bytes discarded
  - IDLE:
    - kb_busy=0, kb_ready=1.
    - Every rx byte is forwarded to scan_data/scan_valid.
    - If the pending flag is set -> LED_CMD.
  - LED_CMD: wait tx_busy=0, send 0xED -> LED_CMD_ACK.
  - LED_CMD_ACK:
    - 0xFA -> LED_ARG
    - 0xFE or timeout -> resend 0xED
  - LED_ARG: send {5'b0, caps, num, scroll} from the pending register -> LED_ARG_ACK.
  - LED_ARG_ACK:
    - 0xFA -> IDLE
    - 0xFE or timeout -> resend argument
  - ERROR: kb_error=1, kb_ready=0, kb_busy=0. Held until reinit or rst_n.
- Bytes other than 0xFA/0xFE received in the LED_* states are forwarded as scancodes; 0xFA/0xFE are consumed.
- Retry counter:
  - Cleared whenever a new byte (not a resend) is sent.
  - Incremented on each 0xFE or timeout.
  - A further resend request while the count equals MAX_RETRY -> ERROR.
- LED pending register:
  - led_update sets the pending flag and latches led_state in any state, including mid-sequence.
  - Multiple requests coalesce: the latest value wins.
  - The flag is cleared when LED_CMD issues tx_start.
  - A request arriving during LED_ARG_ACK is therefore serviced by a fresh 0xED sequence after the return to IDLE.
  - The LED_ARG byte uses the register value at the moment LED_ARG issues tx_start.
- reinit:
  - Goes to RST_SEND; clears the retry counter, timeout counter and kb_error; sets kb_ready=0.
  - The pending LED request is kept and serviced after init.
- Reset:
  - Clears the pending flag and register to 0.
  - Reset mid-transfer abandons the transfer; the FSM restarts at RST_SEND.

## Timing

- tx_start:
  - Asserted the cycle after the FSM is in a send state with tx_busy=0.
  - Exactly one cycle wide.
  - tx_data is valid in the same cycle as tx_start and held until the next send.
- Timeout counter:
  - Cleared on tx_start, and on entry to BAT_WAIT.
  - Increments every cycle while in a wait state.
  - Fires when it reaches TIMEOUT_CYCLES-1; the timeout is a resend or ERROR, as per the state.
  - Width is $clog2(TIMEOUT_CYCLES).
- scan_valid: pulses one cycle after rx_valid, with scan_data=rx_data registered.
- State transition on a response byte: takes effect in the cycle after rx_valid.
- rx_valid coinciding with timeout expiry: the received byte has priority.
- reinit coinciding with rx_valid: reinit has priority and the byte is discarded.
- After a response, the next tx_start is no earlier than 2 cycles after rx_valid, and only once tx_busy=0.

## Test plan

- **Clean init.** Release rst_n; model acks 0xFF with 0xFA, then sends 0xAA. Required: tx_data=0xFF with one tx_start; kb_ready=1, kb_busy=0, kb_error=0.
- **LED update.** In IDLE, pulse led_update with led_state=3'b101; model acks each byte with 0xFA. Required: tx bytes 0xED then 0x05; kb_busy high during the exchange; IDLE afterwards.
- **Resend then exhaustion.** Model answers 0xED with 0xFE once, then 0xFA. Required: 0xED sent twice, then the argument. In a second run, answer 0xFE four times with MAX_RETRY=3. Required: four 0xED transmissions, then kb_error=1.
- **Timeouts.** Set TIMEOUT_CYCLES=100; no response after the argument byte. Required: argument resent 100 cycles after each tx_start; ERROR after the MAX_RETRY resends. Separately, BAT 0xFC during init -> kb_error=1 and kb_ready=0. Then pulse reinit -> 0xFF sent again.
- **Forwarding and coalescing.**
  - In IDLE, rx 0x1C -> scan_valid one cycle later with scan_data=0x1C.
  - During LED_CMD_ACK, rx 0xF0 -> forwarded.
  - In the same window, pulse led_update with 3'b010, then 3'b100. Required: after the current sequence, exactly one new 0xED/0x04 exchange.
- **Reset mid-operation.** Assert rst_n=0 during LED_ARG_ACK. Required: all outputs at reset values immediately. On release, init restarts with 0xFF and no LED exchange follows.

Source files
------------

// File: rtl/ps2_kbd_cmd_sequencer.sv
// Host-side PS/2 keyboard sequencer: reset/BAT handshake, LED updates with
// resend/timeout retries, and scancode forwarding outside protocol replies.
module ps2_kbd_cmd_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       reinit,
    input  logic       led_update,
    input  logic [2:0] led_state,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] scan_data,
    output logic       scan_valid,
    output logic       kb_ready,
    output logic       kb_busy,
    output logic       kb_error
);

    localparam int unsigned TOW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned RW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TOW-1:0] TO_LAST    = TOW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0]  RETRY_LAST = RW'(MAX_RETRY);

    localparam logic [7:0] B_RESET = 8'hFF;
    localparam logic [7:0] B_LED   = 8'hED;
    localparam logic [7:0] B_ACK   = 8'hFA;
    localparam logic [7:0] B_RSND  = 8'hFE;
    localparam logic [7:0] B_BATOK = 8'hAA;

    typedef enum logic [3:0] {
        RST_SEND,
        RST_ACK,
        BAT_WAIT,
        IDLE,
        LED_CMD,
        LED_CMD_ACK,
        LED_ARG,
        LED_ARG_ACK,
        ERROR
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      scan_data_q, scan_data_d;
    logic            scan_valid_q, scan_valid_d;
    logic            kb_ready_q, kb_busy_q, kb_error_q;
    logic [RW-1:0]   retry_q, retry_d;
    logic [TOW-1:0]  to_q, to_d;
    logic            pend_q, pend_d;
    logic [2:0]      led_q, led_d;

    logic            waiting, to_hit, is_ack, is_rsnd;
    logic            fwd, rsnd;
    state_e          rsnd_st;

    assign waiting = (state_q == RST_ACK) || (state_q == BAT_WAIT) ||
                     (state_q == LED_CMD_ACK) || (state_q == LED_ARG_ACK);
    assign to_hit  = waiting && (to_q == TO_LAST);
    assign is_ack  = (rx_data == B_ACK);
    assign is_rsnd = (rx_data == B_RSND);

    always_comb begin
        state_d      = state_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        scan_data_d  = scan_data_q;
        scan_valid_d = 1'b0;
        retry_d      = retry_q;
        to_d         = to_q;
        pend_d       = pend_q;
        led_d        = led_q;
        fwd          = 1'b0;
        rsnd         = 1'b0;
        rsnd_st      = state_q;

        if (waiting && !to_hit)
            to_d = to_q + 1'b1;

        unique case (state_q)
            RST_SEND: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = B_RESET;
                    to_d       = '0;
                    state_d    = RST_ACK;
                end
            end
            RST_ACK: begin
                if (rx_valid) begin
                    if (is_ack) begin
                        state_d = BAT_WAIT;
                        to_d    = '0;
                    end else if (is_rsnd) begin
                        rsnd    = 1'b1;
                        rsnd_st = RST_SEND;
                    end
                end else if (to_hit) begin
                    rsnd    = 1'b1;
                    rsnd_st = RST_SEND;
                end
            end
            BAT_WAIT: begin
                if (rx_valid) begin
                    if (rx_data == B_BATOK)
                        state_d = IDLE;
                    else if (rx_data == 8'hFC || rx_data == 8'hFD)
                        state_d = ERROR;
                end else if (to_hit) begin
                    state_d = ERROR;
                end
            end
            IDLE: begin
                fwd     = rx_valid;
                retry_d = '0;
                if (pend_q)
                    state_d = LED_CMD;
            end
            LED_CMD: begin
                fwd = rx_valid && !is_ack && !is_rsnd;
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = B_LED;
                    to_d       = '0;
                    pend_d     = 1'b0;
                    state_d    = LED_CMD_ACK;
                end
            end
            LED_CMD_ACK: begin
                if (rx_valid) begin
                    if (is_ack) begin
                        retry_d = '0;
                        state_d = LED_ARG;
                    end else if (is_rsnd) begin
                        rsnd    = 1'b1;
                        rsnd_st = LED_CMD;
                    end else begin
                        fwd = 1'b1;
                    end
                end else if (to_hit) begin
                    rsnd    = 1'b1;
                    rsnd_st = LED_CMD;
                end
            end
            LED_ARG: begin
                fwd = rx_valid && !is_ack && !is_rsnd;
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = {5'b0, led_q};
                    to_d       = '0;
                    state_d    = LED_ARG_ACK;
                end
            end
            LED_ARG_ACK: begin
                if (rx_valid) begin
                    if (is_ack) begin
                        state_d = IDLE;
                    end else if (is_rsnd) begin
                        rsnd    = 1'b1;
                        rsnd_st = LED_ARG;
                    end else begin
                        fwd = 1'b1;
                    end
                end else if (to_hit) begin
                    rsnd    = 1'b1;
                    rsnd_st = LED_ARG;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: state_d = RST_SEND;
        endcase

        // A resend request with the budget already spent gives up.
        if (rsnd) begin
            if (retry_q == RETRY_LAST) begin
                state_d = ERROR;
            end else begin
                retry_d = retry_q + 1'b1;
                state_d = rsnd_st;
            end
        end

        if (fwd) begin
            scan_valid_d = 1'b1;
            scan_data_d  = rx_data;
        end

        if (led_update) begin
            pend_d = 1'b1;
            led_d  = led_state;
        end

        if (reinit) begin
            state_d      = RST_SEND;
            tx_start_d   = 1'b0;
            tx_data_d    = tx_data_q;
            scan_valid_d = 1'b0;
            scan_data_d  = scan_data_q;
            retry_d      = '0;
            to_d         = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RST_SEND;
            tx_data_q    <= 8'h00;
            tx_start_q   <= 1'b0;
            scan_data_q  <= 8'h00;
            scan_valid_q <= 1'b0;
            kb_ready_q   <= 1'b0;
            kb_busy_q    <= 1'b1;
            kb_error_q   <= 1'b0;
            retry_q      <= '0;
            to_q         <= '0;
            pend_q       <= 1'b0;
            led_q        <= 3'b000;
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            scan_data_q  <= scan_data_d;
            scan_valid_q <= scan_valid_d;
            kb_ready_q   <= (state_d == IDLE);
            kb_busy_q    <= (state_d != IDLE) && (state_d != ERROR);
            kb_error_q   <= (state_d == ERROR);
            retry_q      <= retry_d;
            to_q         <= to_d;
            pend_q       <= pend_d;
            led_q        <= led_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign scan_data  = scan_data_q;
    assign scan_valid = scan_valid_q;
    assign kb_ready   = kb_ready_q;
    assign kb_busy    = kb_busy_q;
    assign kb_error   = kb_error_q;

endmodule

// File: tb/tb_ps2_kbd_cmd_sequencer.sv
// Scoreboard bench for ps2_kbd_cmd_sequencer: expected tx bytes and scancodes
// are queued by the stimulus and popped by an independent output monitor.
module tb_ps2_kbd_cmd_sequencer;

    localparam int TO = 100;
    localparam int MR = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       reinit;
    logic       led_update;
    logic [2:0] led_state;
    logic       tx_busy;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [7:0] scan_data;
    logic       scan_valid;
    logic       kb_ready;
    logic       kb_busy;
    logic       kb_error;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0] txq[$];
    logic [7:0] scq[$];

    ps2_kbd_cmd_sequencer #(
        .TIMEOUT_CYCLES(TO),
        .MAX_RETRY(MR)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .reinit(reinit),
        .led_update(led_update),
        .led_state(led_state),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .tx_busy(tx_busy),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .scan_data(scan_data),
        .scan_valid(scan_valid),
        .kb_ready(kb_ready),
        .kb_busy(kb_busy),
        .kb_error(kb_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every tx_start / scan_valid consumes one expected entry.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                n_chk++;
                if (txq.size() == 0) begin
                    n_err++;
                    $display("FAIL tx_unexpected: got %02h expected nothing", tx_data);
                end else begin
                    e = txq.pop_front();
                    if (tx_data !== e) begin
                        n_err++;
                        $display("FAIL tx_byte: got %02h expected %02h", tx_data, e);
                    end
                end
            end
            if (scan_valid === 1'b1) begin
                n_chk++;
                if (scq.size() == 0) begin
                    n_err++;
                    $display("FAIL scan_unexpected: got %02h expected nothing", scan_data);
                end else begin
                    e = scq.pop_front();
                    if (scan_data !== e) begin
                        n_err++;
                        $display("FAIL scan_byte: got %02h expected %02h", scan_data, e);
                    end
                end
            end
        end
    end

    // Transmitter model: busy for four cycles after each launch.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_start === 1'b1) begin
                tx_busy = 1'b1;
                repeat (4) @(posedge clk);
                #1;
                tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rx(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic respond(input logic [7:0] b);
        step(6);
        rx(b);
    endtask

    task automatic pulse_led(input logic [2:0] v);
        @(posedge clk);
        #1;
        led_state  = v;
        led_update = 1'b1;
        @(posedge clk);
        #1;
        led_update = 1'b0;
    endtask

    task automatic pulse_reinit();
        @(posedge clk);
        #1;
        reinit = 1'b1;
        @(posedge clk);
        #1;
        reinit = 1'b0;
    endtask

    task automatic wait_tx(input string nm, output int at);
        bit seen;
        seen = 1'b0;
        at   = cyc;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (tx_start === 1'b1) begin
                seen = 1'b1;
                at   = cyc;
            end
        end
        if (!seen) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: got no tx_start expected one within 300 cycles", nm);
        end
    endtask

    task automatic init_seq(input string nm);
        int t;
        wait_tx(nm, t);
        respond(8'hFA);
        respond(8'hAA);
        step(2);
        chk({nm, "_status"}, {29'd0, kb_ready, kb_busy, kb_error}, 32'b100);
    endtask

    function automatic logic [31:0] outs();
        return {11'd0, tx_data, tx_start, scan_data, scan_valid, kb_ready, kb_busy, kb_error};
    endfunction

    localparam logic [31:0] RST_VEC = {11'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int t0;
        int t1;
        rst_n      = 1'b0;
        reinit     = 1'b0;
        led_update = 1'b0;
        led_state  = 3'b000;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;

        step(3);
        chk("reset_outputs", outs(), RST_VEC);

        // Clean init
        txq.push_back(8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        init_seq("init_clean");

        // Forwarding in IDLE
        scq.push_back(8'h1C);
        rx(8'h1C);
        chk("scan_valid_next_cycle", {31'd0, scan_valid}, 32'd1);
        chk("scan_data_idle", {24'd0, scan_data}, 32'h1C);
        step(1);
        chk("scan_valid_one_wide", {31'd0, scan_valid}, 32'd0);

        // LED update 3'b101
        txq.push_back(8'hED);
        txq.push_back(8'h05);
        pulse_led(3'b101);
        wait_tx("led_cmd", t0);
        chk("led_busy_cmd", {30'd0, kb_busy, kb_ready}, 32'b10);
        respond(8'hFA);
        wait_tx("led_arg", t0);
        chk("led_busy_arg", {30'd0, kb_busy, kb_ready}, 32'b10);
        respond(8'hFA);
        step(2);
        chk("led_idle", {29'd0, kb_ready, kb_busy, kb_error}, 32'b100);

        // One resend of 0xED
        txq.push_back(8'hED);
        txq.push_back(8'hED);
        txq.push_back(8'h01);
        pulse_led(3'b001);
        wait_tx("rs_cmd0", t0);
        respond(8'hFE);
        wait_tx("rs_cmd1", t0);
        respond(8'hFA);
        wait_tx("rs_arg", t0);
        respond(8'hFA);
        step(2);
        chk("rs_idle", {29'd0, kb_ready, kb_busy, kb_error}, 32'b100);

        // Resend exhaustion: four 0xED then ERROR
        for (int i = 0; i < MR + 1; i++) txq.push_back(8'hED);
        pulse_led(3'b011);
        for (int i = 0; i < MR + 1; i++) begin
            wait_tx("ex_cmd", t0);
            if (i < MR) chk("ex_not_error_yet", {31'd0, kb_error}, 32'd0);
            respond(8'hFE);
        end
        step(2);
        chk("ex_error", {29'd0, kb_ready, kb_busy, kb_error}, 32'b001);
        txq.push_back(8'hFF);
        pulse_reinit();
        chk("ex_reinit_clears", {29'd0, kb_ready, kb_busy, kb_error}, 32'b010);
        init_seq("ex_reinit");

        // Argument timeouts
        txq.push_back(8'hED);
        for (int i = 0; i < MR + 1; i++) txq.push_back(8'h06);
        pulse_led(3'b110);
        wait_tx("to_cmd", t0);
        respond(8'hFA);
        wait_tx("to_arg0", t0);
        for (int i = 0; i < MR; i++) begin
            wait_tx("to_arg_resend", t1);
            chk("to_interval", {31'd0, (t1 - t0 >= TO) && (t1 - t0 <= TO + 2)}, 32'd1);
            t0 = t1;
        end
        step(TO - 10);
        chk("to_not_error_early", {31'd0, kb_error}, 32'd0);
        step(12);
        chk("to_error", {29'd0, kb_ready, kb_busy, kb_error}, 32'b001);
        txq.push_back(8'hFF);
        pulse_reinit();
        init_seq("to_reinit");

        // BAT failure then reinit
        txq.push_back(8'hFF);
        pulse_reinit();
        wait_tx("bat_rst", t0);
        respond(8'hFA);
        respond(8'hFC);
        step(2);
        chk("bat_fc_error", {29'd0, kb_ready, kb_busy, kb_error}, 32'b001);
        txq.push_back(8'hFF);
        pulse_reinit();
        init_seq("bat_reinit");

        // Forwarding and coalescing during LED_CMD_ACK
        txq.push_back(8'hED);
        txq.push_back(8'h04);
        txq.push_back(8'hED);
        txq.push_back(8'h04);
        pulse_led(3'b001);
        wait_tx("co_cmd0", t0);
        scq.push_back(8'hF0);
        rx(8'hF0);
        chk("co_fwd_valid", {31'd0, scan_valid}, 32'd1);
        pulse_led(3'b010);
        pulse_led(3'b100);
        respond(8'hFA);
        wait_tx("co_arg0", t0);
        respond(8'hFA);
        wait_tx("co_cmd1", t0);
        respond(8'hFA);
        wait_tx("co_arg1", t0);
        respond(8'hFA);
        step(20);
        chk("co_idle", {29'd0, kb_ready, kb_busy, kb_error}, 32'b100);
        chk("co_tx_drained", txq.size(), 32'd0);

        // Reset during LED_ARG_ACK with a pending request
        txq.push_back(8'hED);
        txq.push_back(8'h07);
        pulse_led(3'b111);
        wait_tx("mr_cmd", t0);
        respond(8'hFA);
        wait_tx("mr_arg", t0);
        scq.push_back(8'h2B);
        rx(8'h2B);
        pulse_led(3'b011);
        step(1);
        rst_n = 1'b0;
        #1;
        chk("mr_reset_outputs", outs(), RST_VEC);
        step(3);
        chk("mr_reset_hold", outs(), RST_VEC);
        txq.push_back(8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        init_seq("mr_init");
        step(30);
        chk("mr_no_led_after", {29'd0, kb_ready, kb_busy, kb_error}, 32'b100);

        chk("tx_queue_empty", txq.size(), 32'd0);
        chk("scan_queue_empty", scq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
